// File: rtl/timebase_pkg.sv
// Shared types and elaboration helpers for the time base and its timeout channels.
package timebase_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    EXPIRED
  } ch_state_e;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Prescaler width; it counts 0..div-1, so div >= 2 always needs at least one bit.
  function automatic int presc_w(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/timeout_channel.sv
// One-shot timeout channel: counts ticks down from a loaded value and latches expiry.
module timeout_channel
  import timebase_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             arm,
  input  logic [CNT_W-1:0] arm_val,
  input  logic             cancel,
  output logic             busy,
  output logic             expired
);

  ch_state_e        state, state_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_nxt     = state;
    remaining_nxt = remaining;
    if (cancel) begin
      state_nxt     = IDLE;
      remaining_nxt = '0;
    end else if (arm) begin
      // A load in a tick cycle swallows that tick: the arm branch wins over counting.
      if (arm_val == '0) begin
        state_nxt     = EXPIRED;
        remaining_nxt = '0;
      end else begin
        state_nxt     = RUN;
        remaining_nxt = arm_val;
      end
    end else if (state == RUN && tick) begin
      remaining_nxt = remaining - CNT_W'(1);
      if (remaining == CNT_W'(1)) state_nxt = EXPIRED;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      expired   <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      busy      <= (state_nxt == RUN);
      expired   <= (state_nxt == EXPIRED);
    end
  end

endmodule

// File: rtl/timebase_timers.sv
// Programmable tick prescaler, free-running tick counter with snapshot read,
// and N_CH one-shot timeout channels running off the tick.
module timebase_timers
  import timebase_pkg::*;
#(
  parameter int CLK_HZ  = 200_000_000,
  parameter int TICK_HZ = 1000,
  parameter int TIME_W  = 32,
  parameter int CNT_W   = 16,
  parameter int N_CH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_port,
  output logic              done_port,
  output logic [TIME_W-1:0] return_port,
  output logic              tick,
  input  logic [N_CH-1:0]   arm,
  input  logic [CNT_W-1:0]  arm_val,
  input  logic [N_CH-1:0]   cancel,
  output logic [N_CH-1:0]   busy,
  output logic [N_CH-1:0]   expired
);

  localparam int DIV     = calc_div(CLK_HZ, TICK_HZ);
  localparam int PRESC_W = presc_w(DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_PRE  = PRESC_W'(DIV - 2);

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
    $error("timebase_timers: CLK_HZ/TICK_HZ must be an integer >= 2");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("timebase_timers: N_CH must be in 1..16");
  end

  logic [PRESC_W-1:0] presc;
  logic [TIME_W-1:0]  time_cnt;

  // tick is registered, so it is raised one cycle early: it is high while presc == DIV-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + PRESC_W'(1);
      tick  <= (presc == PRESC_PRE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)     time_cnt <= '0;
    else if (tick) time_cnt <= time_cnt + TIME_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_port   <= 1'b0;
      return_port <= '0;
    end else begin
      done_port <= start_port;
      if (start_port) return_port <= time_cnt;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    timeout_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .arm    (arm[i]),
      .arm_val(arm_val),
      .cancel (cancel[i]),
      .busy   (busy[i]),
      .expired(expired[i])
    );
  end

endmodule

// File: tb/tb_timebase_timers.sv
// Self-checking bench for timebase_timers with DIV=10, 4-bit time, 4 channels.
module tb_timebase_timers;

  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 1;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int TIME_W  = 4;
  localparam int CNT_W   = 8;
  localparam int N_CH    = 4;

  logic              clk;
  logic              reset;
  logic              start_port;
  logic              done_port;
  logic [TIME_W-1:0] return_port;
  logic              tick;
  logic [N_CH-1:0]   arm;
  logic [CNT_W-1:0]  arm_val;
  logic [N_CH-1:0]   cancel;
  logic [N_CH-1:0]   busy;
  logic [N_CH-1:0]   expired;

  timebase_timers #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .TIME_W (TIME_W),
    .CNT_W  (CNT_W),
    .N_CH   (N_CH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_port (start_port),
    .done_port  (done_port),
    .return_port(return_port),
    .tick       (tick),
    .arm        (arm),
    .arm_val    (arm_val),
    .cancel     (cancel),
    .busy       (busy),
    .expired    (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              at_cycle;
    logic [TIME_W-1:0] exp_ret;
  } snap_vec_t;

  typedef struct {
    int              adv;
    logic [N_CH-1:0] arm;
    logic [CNT_W-1:0] val;
    logic [N_CH-1:0] cancel;
    logic [N_CH-1:0] exp_busy;
    logic [N_CH-1:0] exp_expired;
  } ch_vec_t;

  snap_vec_t         snap_tbl[7];
  ch_vec_t           ch_tbl[9];
  logic [TIME_W-1:0] sb_q[$];
  int                n_tests = 0;
  int                n_fail  = 0;
  int                cur_cycle = 0;
  int                m_presc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cur_cycle);
    end
  endtask

  // Advance one clock; checks tick against the prescaler model and done/return via the scoreboard.
  task automatic cycle();
    logic exp_done;
    logic rst_s;
    exp_done = start_port && !reset;
    rst_s    = reset;
    @(posedge clk);
    #1;
    cur_cycle++;
    if (rst_s) m_presc = 0;
    else       m_presc = (m_presc == DIV - 1) ? 0 : m_presc + 1;
    check("tick", tick, (m_presc == DIV - 1));
    check("done", done_port, exp_done);
    if (done_port === 1'b1) begin
      if (sb_q.size() == 0) check("done_unexpected", done_port, 1'b0);
      else                  check("snapshot", return_port, sb_q.pop_front());
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 2 * DIV) begin
      cycle();
      n++;
    end
    check("wait_tick", tick, 1'b1);
  endtask

  initial begin
    int tick_count;
    logic any_active;

    // Snapshot times counted from the first cycle with reset low (cycle 1).
    snap_tbl[0] = '{101, 4'd10};
    snap_tbl[1] = '{155, 4'd15};
    snap_tbl[2] = '{165, 4'd0};
    snap_tbl[3] = '{200, 4'd3};
    snap_tbl[4] = '{201, 4'd4};
    snap_tbl[5] = '{202, 4'd4};
    snap_tbl[6] = '{203, 4'd4};

    // Channel table starts in the cycle after a tick (prescaler at 0).
    ch_tbl[0] = '{0,  4'b0001, 8'd3, 4'b0000, 4'b0001, 4'b0000};
    ch_tbl[1] = '{0,  4'b0010, 8'd0, 4'b0000, 4'b0001, 4'b0010};
    ch_tbl[2] = '{26, 4'b0000, 8'd0, 4'b0000, 4'b0001, 4'b0010};
    ch_tbl[3] = '{0,  4'b0000, 8'd0, 4'b0000, 4'b0000, 4'b0011};
    ch_tbl[4] = '{0,  4'b0100, 8'd5, 4'b0011, 4'b0100, 4'b0000};
    ch_tbl[5] = '{18, 4'b0000, 8'd0, 4'b0000, 4'b0100, 4'b0000};
    ch_tbl[6] = '{0,  4'b1100, 8'd2, 4'b1000, 4'b0100, 4'b0000};
    ch_tbl[7] = '{17, 4'b0000, 8'd0, 4'b0000, 4'b0100, 4'b0000};
    ch_tbl[8] = '{0,  4'b0000, 8'd0, 4'b0000, 4'b0000, 4'b0100};

    reset      = 1'b1;
    start_port = 1'b0;
    arm        = '0;
    arm_val    = '0;
    cancel     = '0;
    cycle();
    cycle();
    check("rst_done", done_port, 1'b0);
    check("rst_return", return_port, 4'd0);
    check("rst_tick", tick, 1'b0);
    check("rst_busy", busy, 4'b0000);
    check("rst_expired", expired, 4'b0000);

    reset     = 1'b0;
    cur_cycle = 1;
    tick_count = 0;
    for (int k = 1; k <= 100; k++) begin
      if (tick === 1'b1) tick_count++;
      cycle();
    end
    check("tick_count_100", tick_count, 10);

    // Snapshots: count 10, wrap 15 -> 0, start in a tick cycle, back-to-back starts.
    for (int i = 0; i < 7; i++) begin
      while (cur_cycle < snap_tbl[i].at_cycle) cycle();
      start_port = 1'b1;
      sb_q.push_back(snap_tbl[i].exp_ret);
      cycle();
      start_port = 1'b0;
    end
    while (cur_cycle < 215) cycle();
    check("return_hold", return_port, 4'd4);

    wait_tick();
    cycle();
    for (int i = 0; i < 9; i++) begin
      arm     = ch_tbl[i].arm;
      arm_val = ch_tbl[i].val;
      cancel  = ch_tbl[i].cancel;
      cycle();
      arm    = '0;
      cancel = '0;
      repeat (ch_tbl[i].adv) cycle();
      check($sformatf("ch_busy_%0d", i), busy, ch_tbl[i].exp_busy);
      check($sformatf("ch_expired_%0d", i), expired, ch_tbl[i].exp_expired);
    end

    // Reset two ticks into a 4-tick timeout, with a snapshot request in the reset cycle.
    cancel = 4'b0100;
    arm     = 4'b1111;
    arm_val = 8'd4;
    cancel  = '0;
    cycle();
    arm = '0;
    check("all_armed", busy, 4'b1111);
    wait_tick();
    cycle();
    wait_tick();
    cycle();
    reset      = 1'b1;
    start_port = 1'b1;
    cycle();
    reset      = 1'b0;
    start_port = 1'b0;
    check("reset_busy", busy, 4'b0000);
    check("reset_expired", expired, 4'b0000);
    any_active = 1'b0;
    repeat (60) begin
      cycle();
      if (busy !== 4'b0000 || expired !== 4'b0000) any_active = 1'b1;
    end
    check("reset_stays_idle", any_active, 1'b0);

    // Arm in a tick cycle: that tick is not counted, expiry comes a full period later.
    wait_tick();
    arm     = 4'b0001;
    arm_val = 8'd1;
    cycle();
    arm = '0;
    check("tickarm_busy", busy, 4'b0001);
    repeat (9) cycle();
    check("tickarm_still_busy", busy, 4'b0001);
    check("tickarm_not_expired", expired, 4'b0000);
    cycle();
    check("tickarm_busy_clear", busy, 4'b0000);
    check("tickarm_expired", expired, 4'b0001);
    cancel = 4'b0001;
    cycle();
    cancel = '0;
    check("cancel_expired", expired, 4'b0000);

    check("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
